// File: rtl/project_final_alarm.sv
// -----------------------------------------------------------------------------
// project_final_alarm
//
// Vehicle warning-alarm controller. Four asynchronous cabin switches are
// synchronized, debounced, combined into a hazard term, and the hazard must
// hold continuously for ALARM_DELAY cycles before the alarm output is raised.
//
// Parameters
//   SYNC_STAGES  flip-flop stages per input synchronizer (>=2)
//   DEBOUNCE     consecutive differing synchronized samples needed to update
//                a debounced input (>=1)
//   ALARM_DELAY  cycles the hazard must hold before A asserts (>=1)
//   PULSE_HALF   0 = A steady high in alarm; N>0 = A toggles every N cycles
//
// Ports
//   clk  in   system clock, all state on rising edge
//   rst  in   asynchronous active-high reset
//   D    in   door open (1 = open), asynchronous
//   K    in   key in ignition (1 = present), asynchronous
//   S    in   driver seat occupied (1 = occupied), asynchronous
//   B    in   seat belt buckled (1 = buckled), asynchronous
//   A    out  alarm drive, registered
// -----------------------------------------------------------------------------
module project_final_alarm #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int ALARM_DELAY = 8,
  parameter int PULSE_HALF  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic D,
  input  logic K,
  input  logic S,
  input  logic B,
  output logic A
);

  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);

  localparam int DLW = $clog2(ALARM_DELAY + 1);
  localparam logic [DLW-1:0] DLY_MAX = DLW'(ALARM_DELAY);

  localparam int PW = (PULSE_HALF > 1) ? $clog2(PULSE_HALF) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'((PULSE_HALF > 0) ? PULSE_HALF - 1 : 0);

  // Bit order: 3 = door, 2 = key, 1 = seat, 0 = belt
  logic [3:0] raw;
  logic [3:0] deb;
  logic       hazard;

  assign raw = {D, K, S, B};

  // ---------------------------------------------------------------------------
  // Per-input synchronizer and debouncer
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_in
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [DBW-1:0]         db_cnt_reg;
      logic                   deb_reg;
      logic                   sync_out;

      assign sync_out = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw[gi]};
        end
      end

      // The counter only runs while the synchronized value disagrees with the
      // debounced one; any agreeing sample restarts the qualification window.
      // Reaching DB_LAST on a further differing sample means DEBOUNCE
      // consecutive differing samples have been seen, so the value is taken.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          db_cnt_reg <= '0;
          deb_reg    <= 1'b0;
        end else if (sync_out == deb_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
          deb_reg    <= sync_out;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end

      assign deb[gi] = deb_reg;
    end
  endgenerate

  // Key present and either door open or occupied seat with unbuckled belt.
  assign hazard = deb[2] & (deb[3] | (deb[1] & ~deb[0]));

  // ---------------------------------------------------------------------------
  // Alarm FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ALARM = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [DLW-1:0] dly_reg,   dly_next;
  logic [PW-1:0]  pcnt_reg,  pcnt_next;
  logic           a_reg,     a_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      dly_reg   <= '0;
      pcnt_reg  <= '0;
      a_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      dly_reg   <= dly_next;
      pcnt_reg  <= pcnt_next;
      a_reg     <= a_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dly_next   = dly_reg;
    pcnt_next  = pcnt_reg;
    a_next     = a_reg;

    case (state_reg)
      IDLE: begin
        a_next    = 1'b0;
        pcnt_next = '0;
        if (hazard) begin
          state_next = WAIT;
          dly_next   = DLW'(1);
        end else begin
          dly_next = '0;
        end
      end

      WAIT: begin
        a_next = 1'b0;
        if (!hazard) begin
          state_next = IDLE;
          dly_next   = '0;
        end else if (dly_reg == DLY_MAX) begin
          // A is registered from a_next, so it rises on the same edge that
          // enters ALARM: ALARM_DELAY+1 cycles after the hazard appeared.
          state_next = ALARM;
          a_next     = 1'b1;
          pcnt_next  = '0;
        end else begin
          dly_next = dly_reg + 1'b1;
        end
      end

      ALARM: begin
        if (!hazard) begin
          state_next = IDLE;
          a_next     = 1'b0;
          dly_next   = '0;
          pcnt_next  = '0;
        end else if (PULSE_HALF == 0) begin
          a_next = 1'b1;
        end else if (pcnt_reg == PULSE_LAST) begin
          // A has held its level for PULSE_HALF cycles; flip it.
          a_next    = ~a_reg;
          pcnt_next = '0;
        end else begin
          pcnt_next = pcnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        a_next     = 1'b0;
        dly_next   = '0;
        pcnt_next  = '0;
      end
    endcase
  end

  assign A = a_reg;

endmodule

// File: tb/tb_project_final_alarm.sv
module tb_project_final_alarm;

  logic clk = 1'b0;
  logic rst;
  logic D, K, S, B;
  logic a_dut;
  logic a_pls;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  project_final_alarm u_dut (
    .clk (clk),
    .rst (rst),
    .D   (D),
    .K   (K),
    .S   (S),
    .B   (B),
    .A   (a_dut)
  );

  project_final_alarm #(.PULSE_HALF(3)) u_pulse (
    .clk (clk),
    .rst (rst),
    .D   (D),
    .K   (K),
    .S   (S),
    .B   (B),
    .A   (a_pls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [3:0] v);
    {D, K, S, B} = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sweep vectors (DKSB) and their hand-evaluated hazard value.
  logic [3:0] combos [8] = '{4'b0000, 4'b0100, 4'b1000, 4'b0111,
                              4'b0010, 4'b1100, 4'b1111, 4'b1110};
  logic       haz    [8] = '{1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b1, 1'b1, 1'b1};
  int         holds  [3] = '{6, 8, 9};

  initial begin
    rst = 1'b1;
    apply(4'b0000);
    #2;
    chk("reset_a", a_dut, 1'b0);
    chk("reset_a_pulse", a_pls, 1'b0);
    step(2);
    rst = 1'b0;
    step(10);
    chk("idle_after_reset", a_dut, 1'b0);

    // Combination sweep: A rises exactly 15 cycles after a hazardous vector.
    for (int c = 0; c < 8; c++) begin
      apply(combos[c]);
      for (int i = 1; i <= 40; i++) begin
        logic e, ep;
        step(1);
        e  = haz[c] && (i >= 15);
        ep = haz[c] && (i >= 15) && ((((i - 15) / 3) % 2) == 0);
        chk($sformatf("combo %b cyc %0d", combos[c], i), a_dut, e);
        chk($sformatf("combo_pulse %b cyc %0d", combos[c], i), a_pls, ep);
      end
      apply(4'b0000);
      for (int i = 1; i <= 12; i++) begin
        step(1);
        if (i == 6) chk($sformatf("combo_clr %b cyc 6", combos[c]), a_dut, haz[c]);
        if (i >= 7) begin
          chk($sformatf("combo_clr %b cyc %0d", combos[c], i), a_dut, 1'b0);
          chk($sformatf("combo_clr_pulse %b cyc %0d", combos[c], i), a_pls, 1'b0);
        end
      end
    end

    // Reset in the middle of an alarm drops A immediately.
    apply(4'b1100);
    step(20);
    chk("pre_reset_alarm", a_dut, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_mid_alarm", a_dut, 1'b0);
    chk("reset_mid_alarm_pulse", a_pls, 1'b0);
    apply(4'b0000);
    step(2);
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      chk($sformatf("post_reset_idle cyc %0d", i), a_dut, 1'b0);
    end
    apply(4'b1100);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      chk($sformatf("post_reset_alarm cyc %0d", i), a_dut, i >= 15);
    end
    apply(4'b0000);
    step(12);

    // Delay abort: hazard held shorter than the delay never alarms; a hold
    // of exactly 9 cycles gives a single-cycle alarm at cycle 15.
    for (int h = 0; h < 3; h++) begin
      apply(4'b1100);
      for (int i = 1; i <= 30; i++) begin
        step(1);
        chk($sformatf("abort hold %0d cyc %0d", holds[h], i), a_dut,
            (holds[h] >= 9) && (i == 15));
        chk($sformatf("abort_pulse hold %0d cyc %0d", holds[h], i), a_pls,
            (holds[h] >= 9) && (i == 15));
        if (i == holds[h]) apply(4'b0000);
      end
      step(5);
    end

    // Glitch handling while in alarm with K=1,D=1.
    apply(4'b1100);
    step(20);
    chk("glitch_base", a_dut, 1'b1);
    D = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      chk($sformatf("glitch3 cyc %0d", i), a_dut, 1'b1);
      if (i == 3) D = 1'b1;
    end
    D = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      step(1);
      chk($sformatf("glitch4 cyc %0d", i), a_dut, (i < 7) || (i >= 19));
      if (i == 4) D = 1'b1;
    end
    apply(4'b0000);
    step(12);

    // Alarm clear via key removal.
    apply(4'b1100);
    step(20);
    chk("clear_base", a_dut, 1'b1);
    K = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      chk($sformatf("clear cyc %0d", i), a_dut, i < 7);
      if (i >= 7) chk($sformatf("clear_pulse cyc %0d", i), a_pls, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
